// File: rtl/slink_vc_credit_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : slink_vc_credit_ctrl_if
// Description : Request, link-flit and credit signals of the multi-VC
//               credit flow controller.
// Revision    : 1.0
// ============================================================================
interface slink_vc_credit_ctrl_if #(
   parameter int NUM_VC      = 2,
   parameter int NUM_CREDITS = 8,
   parameter int DATA_W      = 64
);
   localparam int CNT_W = $clog2(NUM_CREDITS + 1);
   localparam int VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

   logic [NUM_VC-1:0]             tx_valid_i;
   logic [NUM_VC-1:0][DATA_W-1:0] tx_data_i;
   logic [NUM_VC-1:0]             tx_ready_o;
   logic                          tx_valid_o;
   logic                          tx_ready_i;
   logic                          tx_data_valid_o;
   logic [VC_W-1:0]               tx_vc_o;
   logic [DATA_W-1:0]             tx_data_o;
   logic [VC_W-1:0]               tx_credit_vc_o;
   logic [CNT_W-1:0]              tx_credit_o;
   logic                          rx_credit_valid_i;
   logic [VC_W-1:0]               rx_credit_vc_i;
   logic [CNT_W-1:0]              rx_credit_i;
   logic [NUM_VC-1:0]             rx_free_i;
   logic [NUM_VC-1:0][CNT_W-1:0]  credits_o;

   modport slave (
      input  tx_valid_i, tx_data_i, tx_ready_i,
      input  rx_credit_valid_i, rx_credit_vc_i, rx_credit_i, rx_free_i,
      output tx_ready_o, tx_valid_o, tx_data_valid_o, tx_vc_o, tx_data_o,
      output tx_credit_vc_o, tx_credit_o, credits_o
   );

   modport master (
      output tx_valid_i, tx_data_i, tx_ready_i,
      output rx_credit_valid_i, rx_credit_vc_i, rx_credit_i, rx_free_i,
      input  tx_ready_o, tx_valid_o, tx_data_valid_o, tx_vc_o, tx_data_o,
      input  tx_credit_vc_o, tx_credit_o, credits_o
   );
endinterface
`default_nettype wire

// File: rtl/slink_vc_credit_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : slink_vc_credit_ctrl
// Description : Round-robin multi-VC credit flow controller with piggybacked
//               and forced credit-only return flits.
// Revision    : 1.0
// ============================================================================
module slink_vc_credit_ctrl #(
   parameter int NUM_VC            = 2,
   parameter int NUM_CREDITS       = 8,
   parameter int FORCE_SEND_THRESH = NUM_CREDITS - 2,
   parameter int DATA_W            = 64
) (
   input wire logic              clk_i,
   input wire logic              rst_ni,
   slink_vc_credit_ctrl_if.slave bus
);
   localparam int CNT_W = $clog2(NUM_CREDITS + 1);
   localparam int VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

   // First requester at or after ptr, wrapping; lowest offset wins.
   function automatic logic [VC_W-1:0] f_rr_pick(input logic [NUM_VC-1:0] req,
                                                 input logic [VC_W-1:0]   ptr);
      logic [VC_W-1:0] pick;
      int              k;
      pick = '0;
      for (int i = NUM_VC - 1; i >= 0; i--) begin
         k = int'(ptr) + i;
         if (k >= NUM_VC) k = k - NUM_VC;
         if (req[k]) pick = VC_W'(k);
      end
      return pick;
   endfunction

   function automatic logic [VC_W-1:0] f_rr_next(input logic [VC_W-1:0] v);
      int k;
      k = int'(v) + 1;
      if (k >= NUM_VC) k = 0;
      return VC_W'(k);
   endfunction

   logic [CNT_W-1:0]  r_cred [NUM_VC];
   logic [CNT_W-1:0]  r_ret  [NUM_VC];
   logic [VC_W-1:0]   r_rr_d;
   logic [VC_W-1:0]   r_rr_c;
   logic              r_valid;
   logic              r_data_valid;
   logic [VC_W-1:0]   r_vc;
   logic [DATA_W-1:0] r_data;
   logic [VC_W-1:0]   r_credit_vc;
   logic [CNT_W-1:0]  r_credit;

   logic [NUM_VC-1:0] w_elig;
   logic [NUM_VC-1:0] w_has_ret;
   logic [NUM_VC-1:0] w_ret_hit;
   logic              w_any_elig;
   logic              w_force;
   logic              w_slot_free;
   logic              w_load;
   logic              w_grant;
   logic              w_ret_take;
   logic [VC_W-1:0]   w_win;
   logic [VC_W-1:0]   w_cwin;
   logic [CNT_W:0]    w_cred_nxt [NUM_VC];
   logic [CNT_W:0]    w_ret_nxt  [NUM_VC];

   always_comb begin
      w_elig    = '0;
      w_has_ret = '0;
      w_ret_hit = '0;
      for (int v = 0; v < NUM_VC; v++) begin
         w_elig[v]    = bus.tx_valid_i[v] & (r_cred[v] != '0);
         w_has_ret[v] = (r_ret[v] != '0);
         w_ret_hit[v] = (r_ret[v] >= CNT_W'(FORCE_SEND_THRESH));
      end
      w_any_elig  = |w_elig;
      w_force     = ~w_any_elig & (|w_ret_hit);
      w_slot_free = ~r_valid | bus.tx_ready_i;
      w_grant     = w_slot_free & w_any_elig;
      w_load      = w_slot_free & (w_any_elig | w_force);
      w_win       = f_rr_pick(w_elig, r_rr_d);
      w_cwin      = f_rr_pick(w_has_ret, r_rr_c);
      w_ret_take  = w_load & (|w_has_ret);
   end

   // One extra bit on the next-state values so overflow is visible before truncation.
   always_comb begin
      for (int v = 0; v < NUM_VC; v++) begin
         w_cred_nxt[v] = {1'b0, r_cred[v]};
         if (bus.rx_credit_valid_i && (int'(bus.rx_credit_vc_i) == v))
            w_cred_nxt[v] = w_cred_nxt[v] + {1'b0, bus.rx_credit_i};
         if (w_grant && (int'(w_win) == v))
            w_cred_nxt[v] = w_cred_nxt[v] - (CNT_W+1)'(1);
         if (w_ret_take && (int'(w_cwin) == v))
            w_ret_nxt[v] = {CNT_W'(0), bus.rx_free_i[v]};
         else
            w_ret_nxt[v] = {1'b0, r_ret[v]} + {CNT_W'(0), bus.rx_free_i[v]};
      end
   end

   always_comb begin
      bus.tx_ready_o = '0;
      bus.credits_o  = '0;
      for (int v = 0; v < NUM_VC; v++) begin
         bus.tx_ready_o[v] = rst_ni & w_grant & (int'(w_win) == v);
         bus.credits_o[v]  = r_cred[v];
      end
   end

   assign bus.tx_valid_o      = r_valid;
   assign bus.tx_data_valid_o = r_data_valid;
   assign bus.tx_vc_o         = r_vc;
   assign bus.tx_data_o       = r_data;
   assign bus.tx_credit_vc_o  = r_credit_vc;
   assign bus.tx_credit_o     = r_credit;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int v = 0; v < NUM_VC; v++) begin
            r_cred[v] <= CNT_W'(NUM_CREDITS);
            r_ret[v]  <= '0;
         end
         r_rr_d       <= '0;
         r_rr_c       <= '0;
         r_valid      <= 1'b0;
         r_data_valid <= 1'b0;
         r_vc         <= '0;
         r_data       <= '0;
         r_credit_vc  <= '0;
         r_credit     <= '0;
      end else begin
         for (int v = 0; v < NUM_VC; v++) begin
            r_cred[v] <= w_cred_nxt[v][CNT_W-1:0];
            r_ret[v]  <= w_ret_nxt[v][CNT_W-1:0];
         end
         if (w_grant)    r_rr_d <= f_rr_next(w_win);
         if (w_ret_take) r_rr_c <= f_rr_next(w_cwin);
         // Slot free with nothing to send lets the flit drain and valid fall.
         if (w_slot_free) begin
            r_valid <= w_load;
            if (w_load) begin
               r_data_valid <= w_any_elig;
               r_vc         <= w_any_elig ? w_win : '0;
               r_data       <= w_any_elig ? bus.tx_data_i[w_win] : '0;
               r_credit_vc  <= w_cwin;
               r_credit     <= w_ret_take ? r_ret[w_cwin] : '0;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_ni) begin
         for (int v = 0; v < NUM_VC; v++) begin
            assert (w_cred_nxt[v] <= (CNT_W+1)'(NUM_CREDITS));
            assert (w_ret_nxt[v]  <= (CNT_W+1)'(NUM_CREDITS));
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_slink_vc_credit_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_slink_vc_credit_ctrl
// Description : Directed self-checking bench for slink_vc_credit_ctrl.
// Revision    : 1.0
// ============================================================================
module tb_slink_vc_credit_ctrl;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;
   int   acc;

   slink_vc_credit_ctrl_if #(.NUM_VC(2), .NUM_CREDITS(8), .DATA_W(64)) bus ();

   slink_vc_credit_ctrl #(
      .NUM_VC(2), .NUM_CREDITS(8), .FORCE_SEND_THRESH(6), .DATA_W(64)
   ) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n                 = 1'b0;
      bus.tx_valid_i        = 2'b01;
      bus.tx_data_i[0]      = 64'hD0;
      bus.tx_data_i[1]      = 64'hD1;
      bus.tx_ready_i        = 1'b1;
      bus.rx_credit_valid_i = 1'b0;
      bus.rx_credit_vc_i    = 1'b0;
      bus.rx_credit_i       = 4'd0;
      bus.rx_free_i         = 2'b00;
      tick();
      tick();
      check("rst_ready", bus.tx_ready_o, 2'b00);
      check("rst_valid", bus.tx_valid_o, 1'b0);
      check("rst_credits", bus.credits_o, 8'h88);

      // Single VC exhausts its 8 credits
      rst_n = 1'b1;
      #1;
      acc = 0;
      for (int i = 0; i < 10; i++) begin
         acc += int'(bus.tx_ready_o[0]);
         tick();
      end
      check("exhaust_count", acc, 8);
      check("exhaust_credits", bus.credits_o, 8'h80);
      check("exhaust_ready", bus.tx_ready_o, 2'b00);
      check("exhaust_valid", bus.tx_valid_o, 1'b0);

      bus.rx_credit_valid_i = 1'b1;
      bus.rx_credit_vc_i    = 1'b0;
      bus.rx_credit_i       = 4'd3;
      #1;
      check("ret_same_cycle_blocked", bus.tx_ready_o, 2'b00);
      tick();
      bus.rx_credit_valid_i = 1'b0;
      #1;
      check("ret_visible", bus.credits_o, 8'h83);
      check("ret_unblock", bus.tx_ready_o, 2'b01);
      acc = 0;
      for (int i = 0; i < 5; i++) begin
         acc += int'(bus.tx_ready_o[0]);
         tick();
      end
      check("ret_count", acc, 3);
      check("ret_credits", bus.credits_o, 8'h80);

      // Reset restores credits and pointers
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      bus.tx_valid_i = 2'b11;
      #1;

      // Round robin 0,1,0,1
      for (int i = 0; i < 4; i++) begin
         check("rr_grant", bus.tx_ready_o, (i % 2 == 0) ? 2'b01 : 2'b10);
         tick();
         check("rr_vc", bus.tx_vc_o, (i % 2 == 0) ? 1'b0 : 1'b1);
         check("rr_data", bus.tx_data_o, (i % 2 == 0) ? 64'hD0 : 64'hD1);
      end
      check("rr_credits", bus.credits_o, 8'h66);
      bus.tx_valid_i = 2'b00;

      // Piggyback 4 credits of VC1 on a VC0 flit, with a same-cycle free
      bus.rx_free_i = 2'b10;
      for (int i = 0; i < 4; i++) tick();
      check("pb_idle_valid", bus.tx_valid_o, 1'b0);
      bus.tx_valid_i = 2'b01;
      #1;
      check("pb_grant", bus.tx_ready_o, 2'b01);
      tick();
      bus.rx_free_i = 2'b00;
      check("pb_valid", bus.tx_valid_o, 1'b1);
      check("pb_dv", bus.tx_data_valid_o, 1'b1);
      check("pb_vc", bus.tx_vc_o, 1'b0);
      check("pb_credit_vc", bus.tx_credit_vc_o, 1'b1);
      check("pb_credit", bus.tx_credit_o, 4'd4);
      tick();
      check("pb_leftover_vc", bus.tx_credit_vc_o, 1'b1);
      check("pb_leftover", bus.tx_credit_o, 4'd1);
      tick();
      check("pb_drained", bus.tx_credit_o, 4'd0);
      check("pb_credits", bus.credits_o, 8'h63);
      bus.tx_valid_i = 2'b00;

      // Forced credit-only flit at threshold 6
      bus.rx_free_i = 2'b01;
      for (int i = 0; i < 6; i++) tick();
      bus.rx_free_i = 2'b00;
      check("force_below_thresh", bus.tx_valid_o, 1'b0);
      tick();
      check("force_valid", bus.tx_valid_o, 1'b1);
      check("force_dv", bus.tx_data_valid_o, 1'b0);
      check("force_credit_vc", bus.tx_credit_vc_o, 1'b0);
      check("force_credit", bus.tx_credit_o, 4'd6);
      check("force_credits", bus.credits_o, 8'h63);
      tick();
      check("force_once", bus.tx_valid_o, 1'b0);

      // Backpressure holds the flit stable
      bus.tx_ready_i = 1'b0;
      bus.tx_valid_i = 2'b10;
      #1;
      check("bp_grant", bus.tx_ready_o, 2'b10);
      tick();
      bus.tx_data_i[1] = 64'hEE;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("bp_ready", bus.tx_ready_o, 2'b00);
         tick();
         check("bp_valid", bus.tx_valid_o, 1'b1);
         check("bp_vc", bus.tx_vc_o, 1'b1);
         check("bp_data", bus.tx_data_o, 64'hD1);
         check("bp_credits", bus.credits_o, 8'h53);
      end
      bus.tx_ready_i = 1'b1;
      bus.tx_valid_i = 2'b00;
      tick();
      check("bp_drain", bus.tx_valid_o, 1'b0);

      // Return and consumption in the same cycle on VC0
      bus.tx_valid_i = 2'b01;
      tick();
      tick();
      check("sim_pre", bus.credits_o, 8'h51);
      bus.rx_credit_valid_i = 1'b1;
      bus.rx_credit_vc_i    = 1'b0;
      bus.rx_credit_i       = 4'd2;
      #1;
      check("sim_grant", bus.tx_ready_o, 2'b01);
      tick();
      bus.rx_credit_valid_i = 1'b0;
      check("sim_net", bus.credits_o, 8'h52);

      // VC0 at zero credits blocks only VC0
      tick();
      tick();
      check("blk_zero", bus.credits_o, 8'h50);
      bus.tx_valid_i = 2'b11;
      #1;
      check("blk_grant_a", bus.tx_ready_o, 2'b10);
      tick();
      check("blk_grant_b", bus.tx_ready_o, 2'b10);
      tick();
      check("blk_vc", bus.tx_vc_o, 1'b1);
      check("blk_credits", bus.credits_o, 8'h30);
      check("blk_loaded", bus.tx_valid_o, 1'b1);

      // Asynchronous reset mid-operation
      rst_n = 1'b0;
      #1;
      check("mid_rst_ready", bus.tx_ready_o, 2'b00);
      check("mid_rst_valid", bus.tx_valid_o, 1'b0);
      check("mid_rst_credits", bus.credits_o, 8'h88);
      check("mid_rst_credit", bus.tx_credit_o, 4'd0);
      tick();
      rst_n = 1'b1;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
